// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the FSM encoding, buffer entry layout and PC increment helper.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] ADDR_MASK_DEF = 32'h0000_FFFF;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Next sequential word address inside the masked instruction space.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc,
                                                 input logic [ADDR_W-1:0] mask);
        return (pc + ADDR_W'(4)) & mask;
    endfunction

endpackage

// File: rtl/ifetch_buffer.sv
// Small in-order instruction buffer; the oldest entry always sits in slot 0
// so decode sees a registered head with no read mux.
module ifetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [INST_W-1:0] head_inst_o,
    output logic [ADDR_W-1:0] head_pc_o
);

    fetch_entry_t     entry_q [DEPTH];
    fetch_entry_t     entry_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             do_pop;

    // Shift on pop, then write the new entry just above the surviving ones.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        wr_idx  = count_q - CNT_W'(do_pop);
        count_d = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    entry_d[i] = entry_q[i + 1];
                end
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (push_i && (CNT_W'(i) == wr_idx)) begin
                    entry_d[i].inst = push_inst_i;
                    entry_d[i].pc   = push_pc_i;
                end
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign count_o     = count_q;
    assign head_inst_o = entry_q[0].inst;
    assign head_pc_o   = entry_q[0].pc;

    // The fetch credit scheme must never push into a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && !do_pop && (count_q == CNT_W'(DEPTH))))
        else $error("ifetch_buffer overflow");

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers returned
// words for decode and discards responses made stale by a redirect.
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] ADDR_MASK = ADDR_MASK_DEF,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_misalign
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic             run_c;
    logic [SUM_W-1:0] credit_c;

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      rsp_pc_q;
    logic [31:0]      rsp_pc_d;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;
    logic [CNT_W-1:0] kill_q;
    logic [CNT_W-1:0] kill_d;
    logic             misalign_q;
    logic             misalign_d;

    logic [31:0]      target_c;
    logic             req_fire_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] buf_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Credits count both in-flight reads and buffered words, so the request
    // never depends on this cycle's decode handshake.
    always_comb begin
        run_c          = (state_q == RUN);
        credit_c       = SUM_W'(inflight_q) + SUM_W'(buf_count);
        imem_req_valid = run_c && (credit_c < SUM_W'(DEPTH));
    end

    always_comb begin
        target_c   = redirect_pc & ADDR_MASK & ~32'h3;
        req_fire_c = imem_req_valid && imem_req_ready;
        inflight_d = inflight_q + CNT_W'(req_fire_c) - CNT_W'(imem_rsp_valid);
        push_c     = imem_rsp_valid && !redirect_valid && (kill_q == '0);
        pop_c      = inst_valid && inst_ready;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        kill_d     = kill_q;
        misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

        if (imem_rsp_valid && (kill_q != '0)) begin
            kill_d = kill_q - CNT_W'(1);
        end
        if (push_c) begin
            rsp_pc_d = pc_inc(rsp_pc_q, ADDR_MASK);
        end
        if (req_fire_c) begin
            pc_d = pc_inc(pc_q, ADDR_MASK);
        end
        // Everything still outstanding after this cycle belongs to the old path.
        if (redirect_valid) begin
            pc_d     = target_c;
            rsp_pc_d = target_c;
            kill_d   = inflight_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            kill_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            misalign_q <= misalign_d;
        end
    end

    ifetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_c),
        .push_inst_i (imem_rsp_data),
        .push_pc_i   (rsp_pc_q),
        .pop_i       (pop_c),
        .flush_i     (redirect_valid),
        .count_o     (buf_count),
        .head_inst_o (inst_data),
        .head_pc_o   (inst_pc)
    );

    assign imem_req_addr  = pc_q;
    assign inst_valid     = (buf_count != '0);
    assign fetch_misalign = misalign_q;

    a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (inflight_q != '0))
        else $error("ifetch_unit response without outstanding request");

endmodule
